mux81_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 8:1 data mux (MUX81 cell) among 8 requesters.
- Drives the mux select lines SD3..SD1 from a registered 3-bit select and issues a one-hot grant to the requester.
- Enforces an optional maximum hold time and a turnaround gap between owners, so downstream logic never samples a select change mid-transfer.
- Sits beside the mux in the SC library; purely synchronous apart from the reset.

---
 rtl/mux81_rr_sched.sv | 117 +++++++++++
 tb/tb_mux81_rr_sched.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mux81_rr_sched.sv
// Round-robin owner scheduler for a shared 8:1 mux: registered select/grant,
// optional hold timeout and a turnaround gap between owners.
module mux81_rr_sched #(
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       CK,
  input  logic       CDN,
  input  logic [7:0] REQ,
  output logic [7:0] GNT,
  output logic [2:0] SEL,
  output logic       VLD,
  output logic       TOUT
);
  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
  localparam logic [3:0] GAP_C      = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic       vld_q, vld_d;
  logic       tout_q, tout_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gap_q, gap_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] scan_idx;
  logic       timeout;

  // First asserted request scanning upward from the priority pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int i = 0; i < 8; i++) begin
      scan_idx = ptr_q + 3'(i);
      if (!win_found && (REQ[scan_idx] === 1'b1)) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign timeout = (MAX_HOLD_C != 8'd0) && (hold_q == MAX_HOLD_C);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    tout_d  = 1'b0;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = 8'b1 << win_idx;
          sel_d   = win_idx;
          vld_d   = 1'b1;
          hold_d  = 8'd1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Timeout wins over a same-cycle request drop so TOUT still pulses.
        if (timeout || (REQ[sel_q] !== 1'b1)) begin
          gnt_d  = 8'd0;
          vld_d  = 1'b0;
          tout_d = timeout;
          ptr_d  = sel_q + 3'd1;
          hold_d = 8'd0;
          gap_d  = GAP_C;
          state_d = (GAP_C == 4'd0) ? IDLE : GAP;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_q == 4'd0) state_d = IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      state_q <= IDLE;
      gnt_q   <= 8'd0;
      sel_q   <= 3'd0;
      vld_q   <= 1'b0;
      tout_q  <= 1'b0;
      ptr_q   <= 3'd0;
      hold_q  <= 8'd0;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      tout_q  <= tout_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  assign GNT  = gnt_q;
  assign SEL  = sel_q;
  assign VLD  = vld_q;
  assign TOUT = tout_q;
endmodule

// File: tb/tb_mux81_rr_sched.sv
// Scoreboard bench: two schedulers (timeout/gap enabled, and both disabled)
// driven through directed sequences; expectations queued per cycle.
module tb_mux81_rr_sched;
  logic       clk;
  logic       rst_a, rst_b;
  logic [7:0] req_a, req_b;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] sel_a, sel_b;
  logic       vld_a, vld_b, tout_a, tout_b;

  int n_vec = 0;
  int n_err = 0;

  logic [12:0] exp_q[$];
  string       tag_q[$];

  mux81_rr_sched #(.MAX_HOLD(4), .GAP_CYCLES(1)) u_a (
    .CK(clk), .CDN(rst_a), .REQ(req_a),
    .GNT(gnt_a), .SEL(sel_a), .VLD(vld_a), .TOUT(tout_a)
  );

  mux81_rr_sched #(.MAX_HOLD(0), .GAP_CYCLES(0)) u_b (
    .CK(clk), .CDN(rst_b), .REQ(req_b),
    .GNT(gnt_b), .SEL(sel_b), .VLD(vld_b), .TOUT(tout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] obs(input bit b);
    return b ? {gnt_b, sel_b, vld_b, tout_b} : {gnt_a, sel_a, vld_a, tout_a};
  endfunction

  task automatic chk(input string tag, input logic [12:0] o, input logic [12:0] e);
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL %s: got gnt=%h sel=%0d vld=%b tout=%b, want gnt=%h sel=%0d vld=%b tout=%b",
               tag, o[12:5], o[4:2], o[1], o[0], e[12:5], e[4:2], e[1], e[0]);
    end
  endtask

  task automatic step(input string tag, input bit b, input logic [7:0] g,
                      input logic [2:0] s, input logic v, input logic t);
    exp_q.push_back({g, s, v, t});
    tag_q.push_back(tag);
    @(posedge clk); #1;
    chk(tag_q.pop_front(), obs(b), exp_q.pop_front());
  endtask

  // Full ownership on DUT a: 4 held cycles, timeout release, gap, arbitration.
  task automatic own_timeout(input string tag, input logic [2:0] o);
    for (int i = 0; i < 4; i++) step({tag, "_hold"}, 0, 8'b1 << o, o, 1'b1, 1'b0);
    step({tag, "_tout"}, 0, 8'h00, o, 1'b0, 1'b1);
    step({tag, "_gap"},  0, 8'h00, o, 1'b0, 1'b0);
    step({tag, "_arb"},  0, 8'h00, o, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; req_a = 8'h00; req_b = 8'h00;
    #1;
    chk("reset_a", obs(0), 13'd0);
    chk("reset_b", obs(1), 13'd0);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;

    // Single requester, voluntary release, gap, pointer advance check
    step("idle", 0, 8'h00, 3'd0, 1'b0, 1'b0);
    req_a = 8'h04;
    step("t1_grant", 0, 8'h04, 3'd2, 1'b1, 1'b0);
    step("t1_hold",  0, 8'h04, 3'd2, 1'b1, 1'b0);
    step("t1_hold",  0, 8'h04, 3'd2, 1'b1, 1'b0);
    req_a = 8'h00;
    step("t1_rel",   0, 8'h00, 3'd2, 1'b0, 1'b0);
    step("t1_gap",   0, 8'h00, 3'd2, 1'b0, 1'b0);
    step("t1_arb",   0, 8'h00, 3'd2, 1'b0, 1'b0);
    step("t1_idle",  0, 8'h00, 3'd2, 1'b0, 1'b0);
    req_a = 8'h05;  // pointer at 3 -> source 0 beats source 2
    step("t1_ptr",   0, 8'h01, 3'd0, 1'b1, 1'b0);
    req_a = 8'h00;
    step("t1_rel0",  0, 8'h00, 3'd0, 1'b0, 1'b0);
    step("t1_gap0",  0, 8'h00, 3'd0, 1'b0, 1'b0);
    step("t1_arb0",  0, 8'h00, 3'd0, 1'b0, 1'b0);

    // All requesting: rotation 1..7,0,1 with timeout on each owner
    req_a = 8'hFF;
    for (int k = 0; k < 9; k++) own_timeout($sformatf("t2_own%0d", (1 + k) % 8), 3'(1 + k));

    // Wrap: owner 7 times out with 0 pending, 0 served before 7 again
    req_a = 8'h80;
    step("t3_g7", 0, 8'h80, 3'd7, 1'b1, 1'b0);
    req_a = 8'h81;
    for (int i = 0; i < 3; i++) step("t3_h7", 0, 8'h80, 3'd7, 1'b1, 1'b0);
    step("t3_tout7", 0, 8'h00, 3'd7, 1'b0, 1'b1);
    step("t3_gap",   0, 8'h00, 3'd7, 1'b0, 1'b0);
    step("t3_arb",   0, 8'h00, 3'd7, 1'b0, 1'b0);
    step("t3_g0",    0, 8'h01, 3'd0, 1'b1, 1'b0);
    req_a = 8'h80;
    step("t3_rel0",  0, 8'h00, 3'd0, 1'b0, 1'b0);
    step("t3_gap0",  0, 8'h00, 3'd0, 1'b0, 1'b0);
    step("t3_arb0",  0, 8'h00, 3'd0, 1'b0, 1'b0);
    step("t3_g7b",   0, 8'h80, 3'd7, 1'b1, 1'b0);
    req_a = 8'h00;
    step("t3_rel7",  0, 8'h00, 3'd7, 1'b0, 1'b0);
    step("t3_gap7",  0, 8'h00, 3'd7, 1'b0, 1'b0);
    step("t3_arb7",  0, 8'h00, 3'd7, 1'b0, 1'b0);

    // Asynchronous reset mid-grant
    req_a = 8'h10;
    step("t5_g4", 0, 8'h10, 3'd4, 1'b1, 1'b0);
    #2 rst_a = 1'b0;
    #1 chk("t5_async_rst", obs(0), 13'd0);
    req_a = 8'h11;
    @(negedge clk);
    rst_a = 1'b1;
    step("t5_g0", 0, 8'h01, 3'd0, 1'b1, 1'b0);

    // No timeout: 300 cycles of continuous ownership
    req_b = 8'h20;
    step("t4_g5", 1, 8'h20, 3'd5, 1'b1, 1'b0);
    for (int i = 0; i < 299; i++) step("t4_hold", 1, 8'h20, 3'd5, 1'b1, 1'b0);

    // Zero gap: single arbitration cycle between owners
    req_b = 8'h04;
    step("t6_rel5", 1, 8'h00, 3'd5, 1'b0, 1'b0);
    step("t6_g2",   1, 8'h04, 3'd2, 1'b1, 1'b0);
    req_b = 8'h08;
    step("t6_arb",  1, 8'h00, 3'd2, 1'b0, 1'b0);
    step("t6_g3",   1, 8'h08, 3'd3, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
